// File: rtl/sseg_scan_pkg.sv
// Shared definitions for the AXI4-Lite seven-segment scanner.
// Register offsets, field positions, scan states and AXI constants.
package sseg_scan_pkg;

    localparam logic [3:0] REG_CTRL   = 4'h0;
    localparam logic [3:0] REG_DIGITS = 4'h4;
    localparam logic [3:0] REG_MASK   = 4'h8;
    localparam logic [3:0] REG_DIV    = 4'hC;

    localparam int CTRL_EN_BIT    = 0;
    localparam int MASK_DP_LSB    = 0;
    localparam int MASK_BLANK_LSB = 8;

    localparam int DIV_W = 24;

    localparam logic [1:0] AXI_OKAY = 2'b00;

    typedef enum logic [1:0] {
        ST_OFF,
        ST_DRIVE,
        ST_GAP
    } scan_state_t;

    // A slot must be at least two cycles long.
    function automatic logic [DIV_W-1:0] slot_len(input logic [DIV_W-1:0] div);
        return (div < DIV_W'(2)) ? DIV_W'(2) : div;
    endfunction

endpackage

// File: rtl/sseg_hex_decode.sv
// Hex nibble to active-low seven-segment pattern.
// Segment order is {g,f,e,d,c,b,a}.
module sseg_hex_decode (
    input  logic [3:0] hex_i,
    output logic [6:0] seg_o
);

    // Standard hex glyphs, 0 lights a segment.
    always_comb begin
        seg_o = 7'h7F;
        unique case (hex_i)
            4'h0: seg_o = 7'b1000000;
            4'h1: seg_o = 7'b1111001;
            4'h2: seg_o = 7'b0100100;
            4'h3: seg_o = 7'b0110000;
            4'h4: seg_o = 7'b0011001;
            4'h5: seg_o = 7'b0010010;
            4'h6: seg_o = 7'b0000010;
            4'h7: seg_o = 7'b1111000;
            4'h8: seg_o = 7'b0000000;
            4'h9: seg_o = 7'b0010000;
            4'hA: seg_o = 7'b0001000;
            4'hB: seg_o = 7'b0000011;
            4'hC: seg_o = 7'b1000110;
            4'hD: seg_o = 7'b0100001;
            4'hE: seg_o = 7'b0000110;
            4'hF: seg_o = 7'b0001110;
        endcase
    end

endmodule

// File: rtl/sseg_scan_axil.sv
// Multiplexed seven-segment display scanner with an AXI4-Lite
// register port: CTRL, DIGITS, MASK and DIV.
module sseg_scan_axil
    import sseg_scan_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int DEFAULT_DIV = 100000,
    parameter int GAP_CYCLES  = 16
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic [3:0]            S_AXI_AWADDR,
    input  logic                  S_AXI_AWVALID,
    output logic                  S_AXI_AWREADY,
    input  logic [31:0]           S_AXI_WDATA,
    input  logic [3:0]            S_AXI_WSTRB,
    input  logic                  S_AXI_WVALID,
    output logic                  S_AXI_WREADY,
    output logic [1:0]            S_AXI_BRESP,
    output logic                  S_AXI_BVALID,
    input  logic                  S_AXI_BREADY,
    input  logic [3:0]            S_AXI_ARADDR,
    input  logic                  S_AXI_ARVALID,
    output logic                  S_AXI_ARREADY,
    output logic [31:0]           S_AXI_RDATA,
    output logic [1:0]            S_AXI_RRESP,
    output logic                  S_AXI_RVALID,
    input  logic                  S_AXI_RREADY,
    output logic [NUM_DIGITS-1:0] an,
    output logic [6:0]            seg,
    output logic                  dp
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int DIG_W = 4 * NUM_DIGITS;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [DIV_W-1:0] GAP_LAST = DIV_W'(GAP_CYCLES - 1);
    localparam logic [DIV_W-1:0] DIV_RST  = DIV_W'(DEFAULT_DIV);

    logic                  en_q, en_d;
    logic [DIG_W-1:0]      digits_q, digits_d;
    logic [NUM_DIGITS-1:0] dpen_q, dpen_d;
    logic [NUM_DIGITS-1:0] blank_q, blank_d;
    logic [DIV_W-1:0]      div_q, div_d;

    logic        awready_q, awready_d;
    logic        bvalid_q, bvalid_d;
    logic        arready_q, arready_d;
    logic        rvalid_q, rvalid_d;
    logic [31:0] rdata_q, rdata_d;

    logic        wr_fire, rd_fire;
    logic [31:0] bmask, wr_cur, wr_new;

    scan_state_t     state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] len_q, len_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic [6:0]            seg_q, seg_d, hex_seg;
    logic                  dp_q, dp_d;

    // Register readback view; bits without storage read as zero.
    function automatic logic [31:0] reg_word(
        input logic [1:0]            word,
        input logic                  en,
        input logic [DIG_W-1:0]      digits,
        input logic [NUM_DIGITS-1:0] dpen,
        input logic [NUM_DIGITS-1:0] blank,
        input logic [DIV_W-1:0]      div
    );
        logic [31:0] w;
        w = '0;
        case ({word, 2'b00})
            REG_CTRL:   w[CTRL_EN_BIT] = en;
            REG_DIGITS: w[DIG_W-1:0] = digits;
            REG_MASK: begin
                w[MASK_DP_LSB +: NUM_DIGITS]    = dpen;
                w[MASK_BLANK_LSB +: NUM_DIGITS] = blank;
            end
            REG_DIV:    w[DIV_W-1:0] = div;
            default:    w = '0;
        endcase
        return w;
    endfunction

    assign wr_fire = awready_q && S_AXI_AWVALID && S_AXI_WVALID;
    assign rd_fire = arready_q && S_AXI_ARVALID;

    // Handshake next-state and byte-lane merge of the addressed register.
    always_comb begin
        awready_d = S_AXI_AWVALID && S_AXI_WVALID && !bvalid_q && !awready_q;
        arready_d = S_AXI_ARVALID && !rvalid_q && !arready_q;
        bvalid_d  = wr_fire ? 1'b1 : (S_AXI_BREADY ? 1'b0 : bvalid_q);
        rvalid_d  = rd_fire ? 1'b1 : (S_AXI_RREADY ? 1'b0 : rvalid_q);
        rdata_d   = rdata_q;
        if (rd_fire) begin
            rdata_d = reg_word(S_AXI_ARADDR[3:2], en_q, digits_q,
                               dpen_q, blank_q, div_q);
        end
        bmask  = {{8{S_AXI_WSTRB[3]}}, {8{S_AXI_WSTRB[2]}},
                  {8{S_AXI_WSTRB[1]}}, {8{S_AXI_WSTRB[0]}}};
        wr_cur = reg_word(S_AXI_AWADDR[3:2], en_q, digits_q,
                          dpen_q, blank_q, div_q);
        wr_new = (wr_cur & ~bmask) | (S_AXI_WDATA & bmask);
        en_d     = en_q;
        digits_d = digits_q;
        dpen_d   = dpen_q;
        blank_d  = blank_q;
        div_d    = div_q;
        if (wr_fire) begin
            case ({S_AXI_AWADDR[3:2], 2'b00})
                REG_CTRL:   en_d = wr_new[CTRL_EN_BIT];
                REG_DIGITS: digits_d = wr_new[DIG_W-1:0];
                REG_MASK: begin
                    dpen_d  = wr_new[MASK_DP_LSB +: NUM_DIGITS];
                    blank_d = wr_new[MASK_BLANK_LSB +: NUM_DIGITS];
                end
                REG_DIV:    div_d = wr_new[DIV_W-1:0];
                default:    en_d = en_q;
            endcase
        end
    end

    // Byte lanes with no storage and sub-word address bits are don't-care.
    logic unused_ok;
    assign unused_ok = ^{wr_new, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    // AXI channel state and control registers.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            awready_q <= 1'b0;
            bvalid_q  <= 1'b0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            en_q      <= 1'b0;
            digits_q  <= '0;
            dpen_q    <= '0;
            blank_q   <= '0;
            div_q     <= DIV_RST;
        end else begin
            awready_q <= awready_d;
            bvalid_q  <= bvalid_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            en_q      <= en_d;
            digits_q  <= digits_d;
            dpen_q    <= dpen_d;
            blank_q   <= blank_d;
            div_q     <= div_d;
        end
    end

    // Scan sequencing: slot length is captured at each slot start.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        len_d   = len_q;
        if (!en_q) begin
            state_d = ST_OFF;
            cnt_d   = '0;
            idx_d   = '0;
        end else begin
            unique case (state_q)
                ST_OFF: begin
                    state_d = ST_DRIVE;
                    cnt_d   = '0;
                    idx_d   = '0;
                    len_d   = slot_len(div_q);
                end
                ST_DRIVE: begin
                    if (cnt_q == len_q - DIV_W'(1)) begin
                        cnt_d = '0;
                        idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
                        if (GAP_CYCLES == 0) begin
                            state_d = ST_DRIVE;
                            len_d   = slot_len(div_q);
                        end else begin
                            state_d = ST_GAP;
                        end
                    end else begin
                        cnt_d = cnt_q + DIV_W'(1);
                    end
                end
                ST_GAP: begin
                    if (cnt_q == GAP_LAST) begin
                        state_d = ST_DRIVE;
                        cnt_d   = '0;
                        len_d   = slot_len(div_q);
                    end else begin
                        cnt_d = cnt_q + DIV_W'(1);
                    end
                end
                default: state_d = ST_OFF;
            endcase
        end
    end

    // Scan state register.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q <= ST_OFF;
            cnt_q   <= '0;
            len_q   <= slot_len(DIV_RST);
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
        end
    end

    sseg_hex_decode u_dec (
        .hex_i (digits_q[{idx_d, 2'b00} +: 4]),
        .seg_o (hex_seg)
    );

    // Display drive follows the upcoming state so pins align with it.
    always_comb begin
        an_d  = '1;
        seg_d = 7'h7F;
        dp_d  = 1'b1;
        if (state_d == ST_DRIVE) begin
            an_d[idx_d] = blank_q[idx_d];
            seg_d       = hex_seg;
            dp_d        = ~dpen_q[idx_d];
        end
    end

    // Registered display pins.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            an_q  <= '1;
            seg_q <= 7'h7F;
            dp_q  <= 1'b1;
        end else begin
            an_q  <= an_d;
            seg_q <= seg_d;
            dp_q  <= dp_d;
        end
    end

    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = awready_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = AXI_OKAY;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = AXI_OKAY;
    assign an            = an_q;
    assign seg           = seg_q;
    assign dp            = dp_q;

endmodule

// File: tb/tb_sseg_scan_axil.sv
// Directed bench for sseg_scan_axil: register table plus
// hand-written scan, handshake and reset sequences.
module tb_sseg_scan_axil;

    logic        ACLK = 1'b0;
    logic        ARESET = 1'b1;
    logic [3:0]  S_AXI_AWADDR = '0;
    logic        S_AXI_AWVALID = 1'b0;
    logic        S_AXI_AWREADY;
    logic [31:0] S_AXI_WDATA = '0;
    logic [3:0]  S_AXI_WSTRB = '0;
    logic        S_AXI_WVALID = 1'b0;
    logic        S_AXI_WREADY;
    logic [1:0]  S_AXI_BRESP;
    logic        S_AXI_BVALID;
    logic        S_AXI_BREADY = 1'b0;
    logic [3:0]  S_AXI_ARADDR = '0;
    logic        S_AXI_ARVALID = 1'b0;
    logic        S_AXI_ARREADY;
    logic [31:0] S_AXI_RDATA;
    logic [1:0]  S_AXI_RRESP;
    logic        S_AXI_RVALID;
    logic        S_AXI_RREADY = 1'b0;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;

    int tests = 0;
    int fails = 0;

    always #5 ACLK = ~ACLK;

    sseg_scan_axil #(
        .NUM_DIGITS  (4),
        .DEFAULT_DIV (100000),
        .GAP_CYCLES  (1)
    ) dut (
        .ACLK          (ACLK),
        .ARESET        (ARESET),
        .S_AXI_AWADDR  (S_AXI_AWADDR),
        .S_AXI_AWVALID (S_AXI_AWVALID),
        .S_AXI_AWREADY (S_AXI_AWREADY),
        .S_AXI_WDATA   (S_AXI_WDATA),
        .S_AXI_WSTRB   (S_AXI_WSTRB),
        .S_AXI_WVALID  (S_AXI_WVALID),
        .S_AXI_WREADY  (S_AXI_WREADY),
        .S_AXI_BRESP   (S_AXI_BRESP),
        .S_AXI_BVALID  (S_AXI_BVALID),
        .S_AXI_BREADY  (S_AXI_BREADY),
        .S_AXI_ARADDR  (S_AXI_ARADDR),
        .S_AXI_ARVALID (S_AXI_ARVALID),
        .S_AXI_ARREADY (S_AXI_ARREADY),
        .S_AXI_RDATA   (S_AXI_RDATA),
        .S_AXI_RRESP   (S_AXI_RRESP),
        .S_AXI_RVALID  (S_AXI_RVALID),
        .S_AXI_RREADY  (S_AXI_RREADY),
        .an            (an),
        .seg           (seg),
        .dp            (dp)
    );

    typedef struct {
        logic [3:0]  waddr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [3:0]  raddr;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [6:0] hexseg(input logic [3:0] h);
        logic [6:0] t [16] = '{7'h40, 7'h79, 7'h24, 7'h30,
                               7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03,
                               7'h46, 7'h21, 7'h06, 7'h0E};
        return t[h];
    endfunction

    task automatic wait_awready(input string name);
        bit got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge ACLK);
            got = S_AXI_AWREADY;
        end
        if (!got) begin
            tests++;
            fails++;
            $display("FAIL %s: AWREADY timeout got 0 expected 1", name);
        end
    endtask

    task automatic wait_arready(input string name);
        bit got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge ACLK);
            got = S_AXI_ARREADY;
        end
        if (!got) begin
            tests++;
            fails++;
            $display("FAIL %s: ARREADY timeout got 0 expected 1", name);
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d,
                      input logic [3:0] s);
        S_AXI_AWADDR  = a;
        S_AXI_WDATA   = d;
        S_AXI_WSTRB   = s;
        S_AXI_AWVALID = 1'b1;
        S_AXI_WVALID  = 1'b1;
        S_AXI_BREADY  = 1'b1;
        wait_awready("wr");
        @(negedge ACLK);
        S_AXI_AWVALID = 1'b0;
        S_AXI_WVALID  = 1'b0;
        chk("wr bvalid", 32'(S_AXI_BVALID), 32'd1);
        chk("wr bresp", 32'(S_AXI_BRESP), 32'd0);
        @(negedge ACLK);
    endtask

    task automatic rd(input logic [3:0] a, output logic [31:0] d);
        S_AXI_ARADDR  = a;
        S_AXI_ARVALID = 1'b1;
        S_AXI_RREADY  = 1'b1;
        wait_arready("rd");
        @(negedge ACLK);
        S_AXI_ARVALID = 1'b0;
        chk("rd rvalid", 32'(S_AXI_RVALID), 32'd1);
        chk("rd rresp", 32'(S_AXI_RRESP), 32'd0);
        d = S_AXI_RDATA;
        @(negedge ACLK);
    endtask

    // Slot k/5 drives digit (k/5)%4 for 4 cycles, then one gap cycle.
    task automatic check_scan(input int n, input logic [15:0] digs,
                              input logic [15:0] mask);
        for (int k = 0; k < n; k++) begin
            int slot;
            int ph;
            logic [3:0] ea;
            logic [6:0] es;
            logic       ed;
            slot = (k / 5) % 4;
            ph   = k % 5;
            if (ph < 4) begin
                ea = mask[8 + slot] ? 4'hF : ~(4'b0001 << slot);
                es = hexseg(digs[slot*4 +: 4]);
                ed = ~mask[slot];
            end else begin
                ea = 4'hF;
                es = 7'h7F;
                ed = 1'b1;
            end
            chk($sformatf("scan k=%0d an/seg/dp", k),
                32'({an, seg, dp}), 32'({ea, es, ed}));
            @(negedge ACLK);
        end
    endtask

    task automatic run_scan(input logic [15:0] digs, input logic [15:0] mask);
        wr(4'h0, 32'h0, 4'hF);
        wr(4'h8, 32'(mask), 4'hF);
        wr(4'h4, 32'(digs), 4'hF);
        wr(4'h0, 32'h1, 4'hF);
        check_scan(20, digs, mask);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] v;
        logic [3:0]  exp_an [11];

        tbl[0]  = '{4'h4, 32'h0000_1234, 4'hF, 4'h4, 32'h0000_1234};
        tbl[1]  = '{4'h4, 32'hFFFF_FFFF, 4'h1, 4'h4, 32'h0000_12FF};
        tbl[2]  = '{4'h8, 32'hFFFF_FFFF, 4'hF, 4'h8, 32'h0000_0F0F};
        tbl[3]  = '{4'h9, 32'h0000_0000, 4'h2, 4'h8, 32'h0000_000F};
        tbl[4]  = '{4'hC, 32'hFFFF_FFFF, 4'hF, 4'hC, 32'h00FF_FFFF};
        tbl[5]  = '{4'hC, 32'h1234_5678, 4'h4, 4'hD, 32'h0034_FFFF};
        tbl[6]  = '{4'h0, 32'hFFFF_FFFE, 4'hF, 4'h0, 32'h0000_0000};
        tbl[7]  = '{4'h7, 32'h0000_ABCD, 4'h3, 4'h5, 32'h0000_ABCD};
        tbl[8]  = '{4'h8, 32'h0000_0000, 4'hF, 4'hA, 32'h0000_0000};
        tbl[9]  = '{4'hC, 32'h0000_0004, 4'hF, 4'hF, 32'h0000_0004};
        tbl[10] = '{4'h4, 32'h0000_0000, 4'hF, 4'h4, 32'h0000_0000};
        tbl[11] = '{4'h0, 32'h0000_0001, 4'h0, 4'h0, 32'h0000_0000};

        repeat (3) @(negedge ACLK);
        chk("reset an", 32'(an), 32'hF);
        chk("reset seg", 32'(seg), 32'h7F);
        chk("reset dp", 32'(dp), 32'd1);
        chk("reset handshake", 32'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID,
                                    S_AXI_ARREADY, S_AXI_RVALID}), 32'd0);
        chk("reset rdata", S_AXI_RDATA, 32'd0);
        ARESET = 1'b0;
        rd(4'hC, v);
        chk("reset DIV", v, 32'd100000);
        rd(4'h0, v);
        chk("reset CTRL", v, 32'd0);

        for (int i = 0; i < 12; i++) begin
            wr(tbl[i].waddr, tbl[i].wdata, tbl[i].wstrb);
            rd(tbl[i].raddr, v);
            chk($sformatf("reg vec %0d", i), v, tbl[i].exp);
            chk($sformatf("reg vec %0d an idle", i), 32'(an), 32'hF);
        end

        run_scan(16'h1234, 16'h0000);
        run_scan(16'h8765, 16'h0000);
        run_scan(16'hCBA9, 16'h0000);
        run_scan(16'h0FED, 16'h0000);
        run_scan(16'h1234, 16'h0201);

        wr(4'h0, 32'h0, 4'hF);
        wr(4'h8, 32'h0, 4'hF);
        wr(4'h0, 32'h1, 4'hF);
        check_scan(9, 16'h1234, 16'h0000);
        wr(4'h0, 32'h0, 4'hF);
        chk("en clear an off", 32'(an), 32'hF);
        repeat (3) @(negedge ACLK);
        chk("en clear stays off", 32'({an, seg, dp}), 32'({4'hF, 7'h7F, 1'b1}));
        wr(4'h0, 32'h1, 4'hF);
        chk("re-enable digit 0", 32'({an, seg}), 32'({4'hE, 7'h19}));

        wr(4'hC, 32'h6, 4'hF);
        exp_an = '{4'hE, 4'hF, 4'hD, 4'hD, 4'hD, 4'hD,
                   4'hD, 4'hD, 4'hF, 4'hB, 4'hB};
        for (int i = 0; i < 11; i++) begin
            chk($sformatf("div change k=%0d", i + 3), 32'(an), 32'(exp_an[i]));
            @(negedge ACLK);
        end

        wr(4'h0, 32'h0, 4'hF);
        S_AXI_AWADDR  = 4'h4;
        S_AXI_WDATA   = 32'h0000_BEEF;
        S_AXI_WSTRB   = 4'hF;
        S_AXI_AWVALID = 1'b1;
        S_AXI_WVALID  = 1'b0;
        S_AXI_BREADY  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge ACLK);
            chk("aw alone no ready", 32'({S_AXI_AWREADY, S_AXI_WREADY}), 32'd0);
        end
        S_AXI_WVALID = 1'b1;
        wait_awready("hs first");
        chk("hs wready with awready", 32'(S_AXI_WREADY), 32'd1);
        @(negedge ACLK);
        S_AXI_AWADDR = 4'hC;
        S_AXI_WDATA  = 32'h0000_0077;
        for (int i = 0; i < 3; i++) begin
            chk("hs bvalid held", 32'(S_AXI_BVALID), 32'd1);
            chk("hs no second accept", 32'(S_AXI_AWREADY), 32'd0);
            @(negedge ACLK);
        end
        S_AXI_BREADY = 1'b1;
        wait_awready("hs second");
        @(negedge ACLK);
        S_AXI_AWVALID = 1'b0;
        S_AXI_WVALID  = 1'b0;
        chk("hs second bvalid", 32'(S_AXI_BVALID), 32'd1);
        @(negedge ACLK);
        rd(4'h4, v);
        chk("hs first data", v, 32'h0000_BEEF);
        rd(4'hC, v);
        chk("hs second data", v, 32'h0000_0077);

        wr(4'h4, 32'h1234, 4'hF);
        wr(4'hC, 32'h4, 4'hF);
        wr(4'h0, 32'h1, 4'hF);
        S_AXI_ARADDR  = 4'hC;
        S_AXI_ARVALID = 1'b1;
        S_AXI_RREADY  = 1'b0;
        @(negedge ACLK);
        chk("rst arready", 32'(S_AXI_ARREADY), 32'd1);
        @(negedge ACLK);
        S_AXI_ARVALID = 1'b0;
        chk("rst rvalid pending", 32'(S_AXI_RVALID), 32'd1);
        chk("rst rdata pending", S_AXI_RDATA, 32'd4);
        chk("rst mid-slot an", 32'(an), 32'hE);
        #2;
        ARESET = 1'b1;
        #1;
        chk("rst async an", 32'(an), 32'hF);
        chk("rst async seg/dp", 32'({seg, dp}), 32'({7'h7F, 1'b1}));
        chk("rst async rvalid", 32'(S_AXI_RVALID), 32'd0);
        chk("rst async rdata", S_AXI_RDATA, 32'd0);
        @(negedge ACLK);
        ARESET = 1'b0;
        rd(4'hC, v);
        chk("post-reset DIV", v, 32'd100000);
        rd(4'h4, v);
        chk("post-reset DIGITS", v, 32'd0);
        rd(4'h0, v);
        chk("post-reset CTRL", v, 32'd0);
        chk("post-reset an", 32'(an), 32'hF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sseg_scan_axil.md
SSEG_SCAN_AXIL -- requirements
Module: sseg_scan_axil

Interface
REQ-001 The block SHALL have parameter NUM_DIGITS, default 4, giving digits scanned (1..8).
REQ-002 The block SHALL have parameter DEFAULT_DIV, default 100000, giving the reset value of the DIV register (cycles per digit slot).
REQ-003 The block SHALL have parameter GAP_CYCLES, default 16, giving all-anodes-off cycles between slots (0 = no gap).
REQ-004 The block SHALL have port ACLK, input, 1, the single clock for all logic.
REQ-005 The block SHALL have port ARESET, input, 1, an asynchronous active-high reset.
REQ-006 The block SHALL have ports S_AXI_AWADDR/AWVALID/AWREADY, in/in/out, 4/1/1, the AXI4-Lite write-address channel.
REQ-007 The block SHALL have ports S_AXI_WDATA/WSTRB/WVALID/WREADY, in/in/in/out, 32/4/1/1, the write-data channel.
REQ-008 The block SHALL have ports S_AXI_BRESP/BVALID/BREADY, out/out/in, 2/1/1, the write-response channel.
REQ-009 The block SHALL have ports S_AXI_ARADDR/ARVALID/ARREADY, in/in/out, 4/1/1, the read-address channel.
REQ-010 The block SHALL have ports S_AXI_RDATA/RRESP/RVALID/RREADY, out/out/out/in, 32/2/1/1, the read-data channel.
REQ-011 The block SHALL have port an, output, NUM_DIGITS, active-low digit anodes.
REQ-012 The block SHALL have port seg, output, 7, active-low cathodes, seg[6:0] = g,f,e,d,c,b,a.
REQ-013 The block SHALL have port dp, output, 1, active-low decimal point.

Function
REQ-014 Register map SHALL be: 0x0 CTRL (bit0 EN), 0x4 DIGITS (nibble i = hex value of digit i), 0x8 MASK (bits[7:0] DP enable per digit, bits[15:8] blank per digit), 0xC DIV (bits[23:0]).
REQ-015 Reads SHALL return stored values with unimplemented bits (incl. nibbles/mask bits at or above NUM_DIGITS) as 0; BRESP and RRESP SHALL always be 2'b00.
REQ-016 Writes SHALL honour WSTRB per byte; AWADDR[1:0] and ARADDR[1:0] SHALL be ignored.
REQ-017 AWREADY and WREADY SHALL pulse together for one cycle only when AWVALID && WVALID && !BVALID; a lone AWVALID or WVALID SHALL not be accepted.
REQ-018 BVALID SHALL rise the cycle after write acceptance and hold until BREADY is sampled high; register update SHALL be visible on the acceptance edge.
REQ-019 ARREADY SHALL pulse one cycle when ARVALID && !RVALID; RDATA/RVALID SHALL be registered, valid the following cycle, held stable until RREADY.
REQ-020 Scan FSM SHALL have states OFF, DRIVE, GAP; OFF while EN=0; OFF->DRIVE with digit index 0 on the cycle after EN is seen 1.
REQ-021 DRIVE SHALL last exactly max(DIV,2) cycles, then go to GAP (or straight to next DRIVE if GAP_CYCLES=0); GAP SHALL last GAP_CYCLES cycles.
REQ-022 Digit index SHALL increment on leaving DRIVE and wrap NUM_DIGITS-1 -> 0.
REQ-023 A DIV write during a slot SHALL take effect at the next slot start; current slot length SHALL be unchanged.
REQ-024 EN cleared in any state SHALL force OFF next cycle, counters and index to 0.
REQ-025 In DRIVE, an[idx]=0 unless MASK[8+idx]=1 (slot time kept, anode held 1); seg = hex decode of DIGITS nibble idx; dp = ~MASK[idx].
REQ-026 In OFF and GAP, an SHALL be all 1, seg 7'h7F, dp 1.
REQ-027 an, seg, dp SHALL be registered outputs, glitch-free.

Reset
REQ-028 ARESET high SHALL asynchronously set CTRL=0, DIGITS=0, MASK=0, DIV=DEFAULT_DIV, FSM=OFF, an all 1, seg 7'h7F, dp 1, and all AXI READY/VALID outputs 0, RDATA 0, including mid-transaction and mid-slot.
REQ-029 Release of ARESET SHALL require no handshake; first accepted transfer is permitted one cycle after deassertion.

Structure
REQ-030 Package sseg_scan_pkg SHALL hold register offsets, CTRL/MASK bit positions, the FSM state enum and the AXI OKAY response constant.
REQ-031 Combinational sub-module sseg_hex_decode (4-bit hex in, 7-bit active-low segments out) SHALL be instantiated once for the selected digit.

Verification
REQ-032 Write 0x4=0x00001234 WSTRB=0xF, read 0x4 -> RDATA 0x00001234, BRESP=RRESP=00; then write 0x4=0xFFFFFFFF WSTRB=0x1 -> read 0x000012FF.
REQ-033 NUM_DIGITS=4, DIV=4, GAP_CYCLES=1, DIGITS=0x1234, EN=1 -> an=1110 seg=7'b0011001 for 4 cycles, an=1111 for 1, an=1101 seg=7'b0110000 for 4, ..., wraps to 1110 after digit 3.
REQ-034 MASK=0x0201 -> during slot 0 dp=0; during slot 1 an=1111 for full 4 cycles; other slots dp=1.
REQ-035 Clear EN in cycle 2 of slot 2 -> an=1111 next cycle; set EN again -> next DRIVE is digit 0.
REQ-036 AWVALID alone 5 cycles -> no AWREADY; then WVALID -> accept; BREADY low 3 cycles -> BVALID held, no second accept.
REQ-037 Assert ARESET mid-slot with RVALID pending -> an=1111, RVALID=0 immediately; read 0xC -> DEFAULT_DIV.
